// File: rtl/uart_rx_stream.sv
// ---------------------------------------------------------------------------
// uart_rx_stream
//
// UART receiver: deserialises the asynchronous RX line into DATA_WIDTH-bit
// words (LSB first, no parity, one stop bit) and offers each word on a
// valid/ready stream. Each bit is sampled OVERSAMPLE times, and the value is
// a 3-sample majority vote around mid-bit. The receiver rejects glitches on
// the start bit and flags framing and overrun errors.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_pin       asynchronous serial input, idle high
//   rx_data      received word, stable while rx_valid is high
//   rx_valid     word available
//   rx_ready     downstream accepts (transfer on rx_valid && rx_ready)
//   frame_err    one-cycle pulse: stop bit sampled low
//   overrun_err  one-cycle pulse: completed word dropped, output still full
//   busy         receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_stream #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_pin,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int M       = OVERSAMPLE / 2;
    localparam int BW      = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]           s_q, s_d;
    logic [BW-1:0]           bitcnt_q, bitcnt_d;
    logic [1:0]              samp_q, samp_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_err_q, overrun_err_d;

    logic                    rx_s;
    logic                    tick;
    logic                    s_wrap;
    logic                    at_vote;
    logic                    vote;
    logic [DATA_WIDTH-1:0]   bit_sel;

    assign rx_s    = sync2_q;
    assign tick    = (tick_cnt_q == TW'(DIV - 1));
    assign s_wrap  = (s_q == SW'(OVERSAMPLE - 1));
    // The third vote sample is the live value at s=M+1; the first two were
    // captured on the preceding ticks.
    assign at_vote = tick && (s_q == SW'(M + 1));
    assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    // One-hot select of the shift-register bit addressed by the bit counter.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit_sel
            assign bit_sel[gi] = (bitcnt_q == BW'(gi));
        end
    endgenerate

    always_comb begin
        sync1_d       = rx_pin;
        sync2_d       = sync1_q;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + TW'(1);
        state_d       = state_q;
        s_d           = s_q;
        bitcnt_d      = bitcnt_q;
        samp_d        = samp_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        // A pending word leaves on accept; a load below may re-set it.
        rx_valid_d    = rx_valid_q & ~rx_ready;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;

        if (tick) begin
            if (s_q == SW'(M - 1)) samp_d[0] = rx_s;
            if (s_q == SW'(M))     samp_d[1] = rx_s;
            if (state_q != ST_IDLE) s_d = s_wrap ? '0 : s_q + SW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                s_d = '0;
                if (tick && !rx_s) begin
                    state_d = ST_START;
                    s_d     = SW'(1);
                end
            end
            ST_START: begin
                if (at_vote && vote) begin
                    // Low pulse too short to be a start bit.
                    state_d = ST_IDLE;
                    s_d     = '0;
                end else if (tick && s_wrap) begin
                    state_d  = ST_DATA;
                    bitcnt_d = '0;
                end
            end
            ST_DATA: begin
                if (at_vote) begin
                    shift_d = (shift_q & ~bit_sel) | ({DATA_WIDTH{vote}} & bit_sel);
                end
                if (tick && s_wrap) begin
                    bitcnt_d = bitcnt_q + BW'(1);
                    if (bitcnt_q + BW'(1) == BW'(DATA_WIDTH)) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_vote) begin
                    if (vote) begin
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_err_d = 1'b1;
                        end
                        // Return at mid stop bit so the next start edge is
                        // caught with half a bit of margin.
                        state_d = ST_IDLE;
                        s_d     = '0;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) must not look like a new start bit.
                if (tick && rx_s) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            tick_cnt_q    <= '0;
            state_q       <= ST_IDLE;
            s_q           <= '0;
            bitcnt_q      <= '0;
            samp_q        <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            tick_cnt_q    <= tick_cnt_d;
            state_q       <= state_d;
            s_q           <= s_d;
            bitcnt_q      <= bitcnt_d;
            samp_q        <= samp_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_stream.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_stream
//
// Self-checking bench for uart_rx_stream at 16 clk per bit. Expected words
// are queued when a frame is driven and compared when the DUT hands a word
// over (rx_valid && rx_ready). A table of single frames covers the basic
// function; hand-written sequences cover back-to-back traffic, overrun,
// break/framing error, start glitch and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_rx_stream;

    localparam int CLK_FREQ = 16000000;
    localparam int BAUD     = 1000000;
    localparam int OS       = 16;
    localparam int DW       = 8;
    localparam int BIT_CLKS = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_pin = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun_err;
    logic          busy;

    uart_rx_stream #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS),
        .DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_pin     (rx_pin),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_valid;
        int         exp_fe;
        int         exp_ov;
    } vec_t;

    int            checks = 0;
    int            failures = 0;
    logic [7:0]    sb[$];
    int            fe_cnt = 0;
    int            ov_cnt = 0;
    int            valid_cycles = 0;
    int            delivered = 0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [7:0]    prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge after inputs for the next rising edge are set.
    task automatic sample();
        logic [7:0] exp_byte;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(rx_valid), 32'(1));
                check("hold_data", 32'(rx_data), 32'(prev_data));
            end
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=0x%02h required=none", rx_data);
                end else begin
                    exp_byte = sb.pop_front();
                    $display("txn rx_data=0x%02h expected=0x%02h", rx_data, exp_byte);
                    check("rx_data", 32'(rx_data), 32'(exp_byte));
                    delivered++;
                end
            end
            if (frame_err) fe_cnt++;
            if (overrun_err) ov_cnt++;
            prev_valid = rx_valid;
            prev_ready = rx_ready;
            prev_data  = rx_data;
        end
    endtask

    task automatic cycle();
        sample();
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Drives start, data and stop bits; the line is left at the stop value.
    task automatic send_bits(input logic [7:0] d, input logic stop);
        rx_pin = 1'b0;
        cycles(BIT_CLKS);
        for (int b = 0; b < DW; b++) begin
            rx_pin = d[b];
            cycles(BIT_CLKS);
        end
        rx_pin = stop;
        cycles(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(d, stop);
        rx_pin = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            cycle();
            n++;
        end
        check(name, 32'(sb.size()), 32'(0));
    endtask

    vec_t vecs[7];

    initial begin
        int fe0, ov0, vc0, d0;

        vecs[0] = '{data: 8'h83, stop_bit: 1'b1, exp_valid: 1'b1, exp_fe: 0, exp_ov: 0};
        vecs[1] = '{data: 8'h03, stop_bit: 1'b1, exp_valid: 1'b1, exp_fe: 0, exp_ov: 0};
        vecs[2] = '{data: 8'h00, stop_bit: 1'b1, exp_valid: 1'b1, exp_fe: 0, exp_ov: 0};
        vecs[3] = '{data: 8'hFF, stop_bit: 1'b1, exp_valid: 1'b1, exp_fe: 0, exp_ov: 0};
        vecs[4] = '{data: 8'h80, stop_bit: 1'b1, exp_valid: 1'b1, exp_fe: 0, exp_ov: 0};
        vecs[5] = '{data: 8'hAA, stop_bit: 1'b0, exp_valid: 1'b0, exp_fe: 1, exp_ov: 0};
        vecs[6] = '{data: 8'h3C, stop_bit: 1'b1, exp_valid: 1'b1, exp_fe: 0, exp_ov: 0};

        // Reset state
        rst_n    = 1'b0;
        rx_pin   = 1'b1;
        rx_ready = 1'b0;
        @(negedge clk);
        cycles(3);
        check("reset_rx_data", 32'(rx_data), 32'(0));
        check("reset_rx_valid", 32'(rx_valid), 32'(0));
        check("reset_frame_err", 32'(frame_err), 32'(0));
        check("reset_overrun_err", 32'(overrun_err), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        cycles(5);
        rx_ready = 1'b1;

        // Single frames from the table
        for (int i = 0; i < 7; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            vc0 = valid_cycles;
            if (vecs[i].exp_valid) sb.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_bit);
            cycles(20);
            drain("vec_drain");
            check("vec_frame_err", 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
            check("vec_overrun_err", 32'(ov_cnt - ov0), 32'(vecs[i].exp_ov));
            check("vec_valid_cycles", 32'(valid_cycles - vc0), 32'(vecs[i].exp_valid ? 1 : 0));
            check("vec_busy_idle", 32'(busy), 32'(0));
        end

        // Back-to-back: 0x03, 0x00, then 0x00..0x3F with no idle gap
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        d0  = delivered;
        sb.push_back(8'h03);
        send_frame(8'h03, 1'b1);
        sb.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        for (int k = 0; k < 64; k++) begin
            sb.push_back(8'(k));
            send_frame(8'(k), 1'b1);
        end
        cycles(20);
        drain("b2b_drain");
        check("b2b_count", 32'(delivered - d0), 32'(66));
        check("b2b_frame_err", 32'(fe_cnt - fe0), 32'(0));
        check("b2b_overrun_err", 32'(ov_cnt - ov0), 32'(0));

        // Overrun: second word dropped while the first is held
        rx_ready = 1'b0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        send_frame(8'h5A, 1'b1);
        cycles(20);
        check("ovr_valid_held", 32'(rx_valid), 32'(1));
        check("ovr_data_held", 32'(rx_data), 32'(8'hA5));
        check("ovr_pulses", 32'(ov_cnt - ov0), 32'(1));
        check("ovr_frame_err", 32'(fe_cnt - fe0), 32'(0));
        rx_ready = 1'b1;
        cycle();
        check("ovr_valid_cleared", 32'(rx_valid), 32'(0));
        drain("ovr_drain");

        // Framing error followed by a held-low line
        fe0 = fe_cnt;
        vc0 = valid_cycles;
        send_bits(8'h55, 1'b0);
        cycles(40);
        check("fe_busy_low", 32'(busy), 32'(1));
        check("fe_pulses", 32'(fe_cnt - fe0), 32'(1));
        rx_pin = 1'b1;
        cycles(6);
        check("fe_busy_released", 32'(busy), 32'(0));
        check("fe_no_valid", 32'(valid_cycles - vc0), 32'(0));
        sb.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        cycles(20);
        drain("fe_next_drain");

        // Start glitch on an idle line
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        vc0 = valid_cycles;
        rx_pin = 1'b0;
        cycles(5);
        rx_pin = 1'b1;
        cycles(3);
        check("glitch_busy_start", 32'(busy), 32'(1));
        cycles(20);
        check("glitch_busy_idle", 32'(busy), 32'(0));
        check("glitch_no_valid", 32'(valid_cycles - vc0), 32'(0));
        check("glitch_frame_err", 32'(fe_cnt - fe0), 32'(0));
        check("glitch_overrun_err", 32'(ov_cnt - ov0), 32'(0));
        sb.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        cycles(20);
        drain("glitch_next_drain");

        // Reset mid-frame with a word held in the output register
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        cycles(20);
        check("rst_pre_held", 32'(rx_valid), 32'(1));
        rx_pin = 1'b0;
        cycles(BIT_CLKS);
        for (int b = 0; b < 4; b++) begin
            rx_pin = b[0] ? 1'b0 : 1'b1;
            cycles(BIT_CLKS);
        end
        check("rst_pre_busy", 32'(busy), 32'(1));
        rst_n  = 1'b0;
        rx_pin = 1'b1;
        cycles(3);
        check("rst_mid_rx_data", 32'(rx_data), 32'(0));
        check("rst_mid_rx_valid", 32'(rx_valid), 32'(0));
        check("rst_mid_frame_err", 32'(frame_err), 32'(0));
        check("rst_mid_overrun_err", 32'(overrun_err), 32'(0));
        check("rst_mid_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        cycles(5);
        check("rst_post_valid", 32'(rx_valid), 32'(0));
        rx_ready = 1'b1;
        d0 = delivered;
        cycles(5);
        sb.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        cycles(20);
        drain("rst_next_drain");
        check("rst_delivered", 32'(delivered - d0), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
